// File: rtl/ifu_litebpu_pkg.sv
// Shared widths, FSM state encodings and op1 selector for the IFU lite branch predictor.
package ifu_litebpu_pkg;

  localparam int BPU_PC_SIZE     = 32;
  localparam int BPU_XLEN        = 32;
  localparam int BPU_RFIDX_WIDTH = 5;

  typedef enum logic [1:0] {
    BPU_IDLE    = 2'b00,
    BPU_XN_WAIT = 2'b01,
    BPU_XN_RD   = 2'b10
  } bpu_state_e;

  typedef enum logic [1:0] {
    OP1_PC   = 2'b00,
    OP1_ZERO = 2'b01,
    OP1_X1   = 2'b10,
    OP1_RS1  = 2'b11
  } bpu_op1_sel_e;

endpackage

// File: rtl/ifu_bpu_adder.sv
// Target adder: op1 mux followed by a PC_SIZE-wide wrap-around add of the immediate.
// Shared with the EXU branch resolver, so it carries no state.
module ifu_bpu_adder
  import ifu_litebpu_pkg::*;
#(
  parameter int PC_SIZE = BPU_PC_SIZE,
  parameter int XLEN    = BPU_XLEN
) (
  input  bpu_op1_sel_e       op1_sel,
  input  logic [PC_SIZE-1:0] pc,
  input  logic [XLEN-1:0]    x1_val,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic [XLEN-1:0]    imm,
  output logic [PC_SIZE-1:0] sum
);

  logic [PC_SIZE-1:0] op1_s;

  // Operand 1 selection
  always_comb begin
    op1_s = {PC_SIZE{1'b0}};
    case (op1_sel)
      OP1_PC:   op1_s = pc;
      OP1_ZERO: op1_s = {PC_SIZE{1'b0}};
      OP1_X1:   op1_s = x1_val[PC_SIZE-1:0];
      OP1_RS1:  op1_s = rs1_val[PC_SIZE-1:0];
      default:  op1_s = {PC_SIZE{1'b0}};
    endcase
  end

  // Carry out is dropped on purpose: targets wrap around the address space
  always_comb begin
    sum = op1_s + imm[PC_SIZE-1:0];
  end

endmodule

// File: rtl/ifu_litebpu_seq.sv
// Static branch predictor: same-cycle prediction for jal/bxx/jalr x0/x1, and a
// small FSM that sequences the register-file read for jalr through a general register.
module ifu_litebpu_seq
  import ifu_litebpu_pkg::*;
#(
  parameter int PC_SIZE     = BPU_PC_SIZE,
  parameter int XLEN        = BPU_XLEN,
  parameter int RFIDX_WIDTH = BPU_RFIDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic                   oitf_empty,
  input  logic                   ir_empty,
  input  logic                   ir_rs1en,
  input  logic                   jalr_rs1idx_cam_irrdidx,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  output logic                   bpu2rf_rs1_ena,
  output logic                   bpu_wait,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc
);

  bpu_state_e         state_r;
  bpu_op1_sel_e       op1_sel_s;
  logic [PC_SIZE-1:0] sum_s;
  logic               rs1_is_x0_s;
  logic               rs1_is_x1_s;
  logic               jalr_x1_s;
  logic               jalr_xn_s;
  logic               x1_dep_s;
  logic               xn_dep_s;
  logic               port_busy_s;
  logic               xn_go_s;
  logic               rs1_ena_s;
  logic               wait_s;

  // Instruction classification and hazard terms
  always_comb begin
    rs1_is_x0_s = (dec_jalr_rs1idx == {RFIDX_WIDTH{1'b0}});
    rs1_is_x1_s = (dec_jalr_rs1idx == {{(RFIDX_WIDTH-1){1'b0}}, 1'b1});
    jalr_x1_s   = dec_i_valid & dec_jalr & rs1_is_x1_s;
    jalr_xn_s   = dec_i_valid & dec_jalr & ~rs1_is_x0_s & ~rs1_is_x1_s;
    x1_dep_s    = ~oitf_empty | (~ir_empty & jalr_rs1idx_cam_irrdidx);
    xn_dep_s    = ~oitf_empty | ~ir_empty;
    port_busy_s = ~ir_empty & ir_rs1en;
    xn_go_s     = ~xn_dep_s & ~port_busy_s;
  end

  // Operand 1 source for the target adder
  always_comb begin
    if (dec_jalr) begin
      if (rs1_is_x0_s) begin
        op1_sel_s = OP1_ZERO;
      end else if (rs1_is_x1_s) begin
        op1_sel_s = OP1_X1;
      end else begin
        op1_sel_s = OP1_RS1;
      end
    end else begin
      op1_sel_s = OP1_PC;
    end
  end

  ifu_bpu_adder #(
    .PC_SIZE (PC_SIZE),
    .XLEN    (XLEN)
  ) u_adder (
    .op1_sel (op1_sel_s),
    .pc      (pc),
    .x1_val  (rf2bpu_x1),
    .rs1_val (rf2bpu_rs1),
    .imm     (dec_bjp_imm),
    .sum     (sum_s)
  );

  // Stall and read-request decode per FSM state
  always_comb begin
    rs1_ena_s = 1'b0;
    wait_s    = 1'b0;
    case (state_r)
      BPU_IDLE: begin
        if (jalr_x1_s) begin
          wait_s = x1_dep_s;
        end else if (jalr_xn_s) begin
          wait_s    = 1'b1;
          rs1_ena_s = xn_go_s & ~flush;
        end else begin
          wait_s = 1'b0;
        end
      end
      BPU_XN_WAIT: begin
        if (dec_i_valid) begin
          wait_s    = 1'b1;
          rs1_ena_s = xn_go_s & ~flush;
        end else begin
          wait_s = 1'b0;
        end
      end
      BPU_XN_RD: begin
        wait_s    = 1'b0;
        rs1_ena_s = 1'b0;
      end
      default: begin
        wait_s    = 1'b0;
        rs1_ena_s = 1'b0;
      end
    endcase
  end

  // Prediction outputs; the read request is held off while reset is asserted
  always_comb begin
    bpu2rf_rs1_ena = rs1_ena_s & rst_n;
    bpu_wait       = wait_s;
    if (dec_i_valid) begin
      prdt_taken = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]);
      prdt_pc    = sum_s;
    end else begin
      prdt_taken = 1'b0;
      prdt_pc    = {PC_SIZE{1'b0}};
    end
  end

  // jalr operand fetch sequencer; flush overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BPU_IDLE;
    end else if (flush) begin
      state_r <= BPU_IDLE;
    end else begin
      case (state_r)
        BPU_IDLE: begin
          if (jalr_xn_s) begin
            state_r <= xn_go_s ? BPU_XN_RD : BPU_XN_WAIT;
          end else begin
            state_r <= BPU_IDLE;
          end
        end
        BPU_XN_WAIT: begin
          if (!dec_i_valid) begin
            state_r <= BPU_IDLE;
          end else if (xn_go_s) begin
            state_r <= BPU_XN_RD;
          end else begin
            state_r <= BPU_XN_WAIT;
          end
        end
        BPU_XN_RD: state_r <= BPU_IDLE;
        default:   state_r <= BPU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_litebpu_seq.sv
// Directed bench for ifu_litebpu_seq: per-scenario tasks with hand-computed expectations.
module tb_ifu_litebpu_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] pc;
  logic        dec_i_valid;
  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_bxx;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1idx;
  logic        oitf_empty;
  logic        ir_empty;
  logic        ir_rs1en;
  logic        jalr_rs1idx_cam_irrdidx;
  logic [31:0] rf2bpu_x1;
  logic [31:0] rf2bpu_rs1;
  logic        bpu2rf_rs1_ena;
  logic        bpu_wait;
  logic        prdt_taken;
  logic [31:0] prdt_pc;

  int checks = 0;
  int errors = 0;
  logic [2:0] obs;

  ifu_litebpu_seq dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .pc                      (pc),
    .dec_i_valid             (dec_i_valid),
    .dec_jal                 (dec_jal),
    .dec_jalr                (dec_jalr),
    .dec_bxx                 (dec_bxx),
    .dec_bjp_imm             (dec_bjp_imm),
    .dec_jalr_rs1idx         (dec_jalr_rs1idx),
    .oitf_empty              (oitf_empty),
    .ir_empty                (ir_empty),
    .ir_rs1en                (ir_rs1en),
    .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx),
    .rf2bpu_x1               (rf2bpu_x1),
    .rf2bpu_rs1              (rf2bpu_rs1),
    .bpu2rf_rs1_ena          (bpu2rf_rs1_ena),
    .bpu_wait                (bpu_wait),
    .prdt_taken              (prdt_taken),
    .prdt_pc                 (prdt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb obs = {bpu_wait, bpu2rf_rs1_ena, prdt_taken};

  task automatic bus(input logic v, input logic jal, input logic jalr, input logic bxx,
                     input logic [31:0] imm, input logic [4:0] idx);
    dec_i_valid     = v;
    dec_jal         = jal;
    dec_jalr        = jalr;
    dec_bxx         = bxx;
    dec_bjp_imm     = imm;
    dec_jalr_rs1idx = idx;
  endtask

  task automatic deps(input logic oe, input logic ie, input logic rs1en, input logic cam);
    oitf_empty              = oe;
    ir_empty                = ie;
    ir_rs1en                = rs1en;
    jalr_rs1idx_cam_irrdidx = cam;
  endtask

  task automatic test_reset();
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0); #1;
    checks++; if (obs !== 3'b000) begin $display("FAIL reset_idle: wait/ena/taken=%b expected 000", obs); errors++; end
    checks++; if (prdt_pc !== 32'h0) begin $display("FAIL reset_pc: got %h expected 00000000", prdt_pc); errors++; end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd5); #1;
    checks++; if (obs !== 3'b101) begin $display("FAIL reset_xn_no_ena: wait/ena/taken=%b expected 101", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0); rst_n = 1'b1;
  endtask

  task automatic test_bxx();
    @(negedge clk); pc = 32'h8000_0100; bus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 5'd0); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL bxx_back_flags: wait/ena/taken=%b expected 001", obs); errors++; end
    checks++; if (prdt_pc !== 32'h8000_00F0) begin $display("FAIL bxx_back_pc: got %h expected 800000f0", prdt_pc); errors++; end
    @(negedge clk); bus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd0); #1;
    checks++; if (obs !== 3'b000) begin $display("FAIL bxx_fwd_flags: wait/ena/taken=%b expected 000", obs); errors++; end
  endtask

  task automatic test_jal();
    @(negedge clk); pc = 32'hFFFF_FFFC; bus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 5'd0); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL jal_flags: wait/ena/taken=%b expected 001", obs); errors++; end
    checks++; if (prdt_pc !== 32'h0000_0004) begin $display("FAIL jal_wrap_pc: got %h expected 00000004", prdt_pc); errors++; end
  endtask

  task automatic test_jalr_x1();
    rf2bpu_x1 = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); deps(1'b0, 1'b1, 1'b0, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 5'd1); #1;
      checks++; if (obs !== 3'b101) begin $display("FAIL x1_wait_%0d: wait/ena/taken=%b expected 101", i, obs); errors++; end
    end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL x1_release: wait/ena/taken=%b expected 001", obs); errors++; end
    checks++; if (prdt_pc !== 32'h0000_2004) begin $display("FAIL x1_pc: got %h expected 00002004", prdt_pc); errors++; end
    @(negedge clk); deps(1'b1, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (obs !== 3'b101) begin $display("FAIL x1_cam_dep: wait/ena/taken=%b expected 101", obs); errors++; end
    @(negedge clk); deps(1'b1, 1'b0, 1'b1, 1'b0); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL x1_no_cam: wait/ena/taken=%b expected 001", obs); errors++; end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_jalr_xn();
    rf2bpu_rs1 = 32'h0000_3000;
    rf2bpu_x1  = 32'h0000_2000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); deps(1'b1, 1'b0, 1'b1, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 5'd5); #1;
      checks++; if (obs !== 3'b101) begin $display("FAIL xn_wait_%0d: wait/ena/taken=%b expected 101", i, obs); errors++; end
    end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (obs !== 3'b111) begin $display("FAIL xn_request: wait/ena/taken=%b expected 111", obs); errors++; end
    @(negedge clk); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL xn_data_flags: wait/ena/taken=%b expected 001", obs); errors++; end
    checks++; if (prdt_pc !== 32'h0000_2FFE) begin $display("FAIL xn_data_pc: got %h expected 00002ffe", prdt_pc); errors++; end
    @(negedge clk); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd1); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL xn_back_idle: wait/ena/taken=%b expected 001", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_flush();
    @(negedge clk); deps(1'b1, 1'b0, 1'b1, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 5'd5); #1;
    checks++; if (obs !== 3'b101) begin $display("FAIL flush_enter_wait: wait/ena/taken=%b expected 101", obs); errors++; end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); flush = 1'b1; #1;
    checks++; if (bpu2rf_rs1_ena !== 1'b0) begin $display("FAIL flush_no_ena: got %b expected 0", bpu2rf_rs1_ena); errors++; end
    @(negedge clk); flush = 1'b0; bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd1); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL flush_idle: wait/ena/taken=%b expected 001", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_reset_mid();
    rf2bpu_rs1 = 32'h0000_1000;
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 5'd7); #1;
    checks++; if (obs !== 3'b111) begin $display("FAIL rstmid_request: wait/ena/taken=%b expected 111", obs); errors++; end
    @(negedge clk); #1;
    checks++; if (prdt_pc !== 32'h0000_1010) begin $display("FAIL rstmid_rd_pc: got %h expected 00001010", prdt_pc); errors++; end
    #1 rst_n = 1'b0; #1;
    checks++; if (obs !== 3'b101) begin $display("FAIL rstmid_async_idle: wait/ena/taken=%b expected 101", obs); errors++; end
    @(negedge clk); #1;
    checks++; if (bpu2rf_rs1_ena !== 1'b0) begin $display("FAIL rstmid_hold_ena: got %b expected 0", bpu2rf_rs1_ena); errors++; end
    bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd1); rst_n = 1'b1; #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL rstmid_after: wait/ena/taken=%b expected 001", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_abandon();
    @(negedge clk); deps(1'b0, 1'b1, 1'b0, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd9); #1;
    checks++; if (obs !== 3'b101) begin $display("FAIL abandon_wait: wait/ena/taken=%b expected 101", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd9); #1;
    checks++; if (obs !== 3'b000) begin $display("FAIL abandon_invalid: wait/ena/taken=%b expected 000", obs); errors++; end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd1); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL abandon_idle: wait/ena/taken=%b expected 001", obs); errors++; end
    @(negedge clk); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_jalr_x0();
    @(negedge clk); pc = 32'h8000_0000; deps(1'b0, 1'b0, 1'b1, 1'b1); bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 5'd0); #1;
    checks++; if (obs !== 3'b001) begin $display("FAIL x0_flags: wait/ena/taken=%b expected 001", obs); errors++; end
    checks++; if (prdt_pc !== 32'h0000_0100) begin $display("FAIL x0_pc: got %h expected 00000100", prdt_pc); errors++; end
    @(negedge clk); deps(1'b1, 1'b1, 1'b0, 1'b0); bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    pc = 32'h0;
    rf2bpu_x1 = 32'h0;
    rf2bpu_rs1 = 32'h0;
    deps(1'b1, 1'b1, 1'b0, 1'b0);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    test_reset();
    test_bxx();
    test_jal();
    test_jalr_x1();
    test_jalr_xn();
    test_flush();
    test_reset_mid();
    test_abandon();
    test_jalr_x0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_litebpu_seq.md
Name: ifu_litebpu_seq

Overview:
- Static branch predictor in the IFU. It consumes the mini-decoder info-bus (jal/jalr/bxx flags, immediate, jalr rs1 index) for the instruction being fetched.
- It produces the taken prediction and the predicted target PC.
- It sequences the jalr rs1 operand fetch: a dependency wait, then a one-cycle register-file read-port request.
- Sits between the mini-decoder and the fetch PC mux. It stalls fetch via bpu_wait.

Parameters:
- PC_SIZE, 32, width of PC and target.
- XLEN, 32, register/immediate width.
- RFIDX_WIDTH, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; abandons any pending jalr operand fetch
- pc  in  PC_SIZE  PC of the decoded instruction
- dec_i_valid  in  1  info-bus valid; held stable by fetch while bpu_wait=1
- dec_jal  in  1  instruction is jal
- dec_jalr  in  1  instruction is jalr
- dec_bxx  in  1  instruction is conditional branch
- dec_bjp_imm  in  XLEN  sign-extended branch/jump immediate
- dec_jalr_rs1idx  in  RFIDX_WIDTH  jalr rs1 index
- oitf_empty  in  1  no long-pipe instruction outstanding
- ir_empty  in  1  IR stage holds no valid instruction
- ir_rs1en  in  1  IR instruction uses read port 1 this cycle
- jalr_rs1idx_cam_irrdidx  in  1  IR instruction writes the register named by dec_jalr_rs1idx
- rf2bpu_x1  in  XLEN  dedicated x1 read value
- rf2bpu_rs1  in  XLEN  read port 1 data, valid the cycle after bpu2rf_rs1_ena
- bpu2rf_rs1_ena  out  1  request read port 1 with index dec_jalr_rs1idx
- bpu_wait  out  1  stall fetch; prediction not yet valid
- prdt_taken  out  1  predicted taken
- prdt_pc  out  PC_SIZE  predicted target

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Prediction, combinational, gated by dec_i_valid:
  - jal: taken.
  - jalr: taken.
  - bxx: taken iff dec_bjp_imm[XLEN-1]=1 (backward taken, forward not taken).
  - Otherwise prdt_taken=0.
- Target: prdt_pc = op1 + dec_bjp_imm, truncated to PC_SIZE, wrap-around with no overflow flag. op1 is selected as:
  - jal/bxx: op1 = pc.
  - jalr with rs1=x0: op1 = 0.
  - jalr with rs1=x1: op1 = rf2bpu_x1.
  - jalr with rs1=xN: op1 = rf2bpu_rs1.
- prdt_pc is don't-care when prdt_taken=0.
- Dependency terms:
  - x1 dependency = ~oitf_empty | (~ir_empty & jalr_rs1idx_cam_irrdidx).
  - xN dependency = ~oitf_empty | ~ir_empty.
  - Port busy = ~ir_empty & ir_rs1en.
- FSM states: IDLE, XN_WAIT, XN_RD. Encoding is internal to the block.
- IDLE:
  - jalr x0, jal, bxx, non-branch: bpu_wait=0, prediction valid same cycle.
  - jalr x1: bpu_wait = x1 dependency. Stays IDLE, no flop involved.
  - jalr xN, dependency clear and port not busy: bpu2rf_rs1_ena=1, bpu_wait=1, go to XN_RD.
  - jalr xN, otherwise: bpu_wait=1, go to XN_WAIT.
- XN_WAIT:
  - bpu_wait=1.
  - When dependency clear and port not busy: bpu2rf_rs1_ena=1, go to XN_RD.
- XN_RD:
  - Lasts exactly one cycle. bpu_wait=0; prdt_pc uses rf2bpu_rs1.
  - Fetch must accept the prediction this cycle.
  - Unconditionally return to IDLE.
- bpu2rf_rs1_ena is never asserted in two consecutive cycles.
- flush: has priority over every transition. Next state is IDLE, and bpu2rf_rs1_ena=0 in the flush cycle.
- dec_i_valid=0 in XN_WAIT: treated as an implicit abandon; return to IDLE.
- Reset, including mid-operation: state is IDLE.
  - bpu2rf_rs1_ena=0 while reset is asserted.
  - bpu_wait, prdt_taken and prdt_pc follow the IDLE combinational equations; all are 0 when dec_i_valid=0.
- Latency summary:
  - jal/bxx/jalr x0: 0 cycles.
  - jalr x1: 0 cycles plus dependency duration.
  - jalr xN: 1 cycle (request) + wait cycles + 1 cycle (data).

Decomposition:
- Shared defines header: PC_SIZE, XLEN, RFIDX_WIDTH, and the FSM state encodings.
- One natural sub-module: ifu_bpu_adder. It holds the op1 mux and the PC_SIZE-wide adder, and is reusable by the EXU branch resolver.
- The FSM state register stays in ifu_litebpu_seq.

Test Plan:
1. bxx, pc=0x8000_0100, imm=0xFFFF_FFF0 -> same cycle prdt_taken=1, prdt_pc=0x8000_00F0, bpu_wait=0. Same with imm=0x10 -> prdt_taken=0.
2. jal, pc=0xFFFF_FFFC, imm=0x8 -> prdt_pc=0x0000_0004 (wrap-around), prdt_taken=1.
3. jalr x1, rf2bpu_x1=0x2000, imm=4, oitf_empty=0 for 3 cycles -> bpu_wait=1 for 3 cycles, then prdt_pc=0x2004, bpu2rf_rs1_ena never asserted.
4. jalr x5, ir_empty=0 with ir_rs1en=1 for 2 cycles, then IR empties -> bpu_wait=1 for 2 cycles, then bpu2rf_rs1_ena pulses for 1 cycle. Next cycle, with rf2bpu_rs1=0x3000 and imm=0xFFFF_FFFE: bpu_wait=0, prdt_pc=0x2FFE; state returns to IDLE.
5. jalr x5 in XN_WAIT, flush asserted -> next cycle IDLE, no bpu2rf_rs1_ena pulse. Same scenario with rst_n dropped in XN_RD -> immediately IDLE, bpu2rf_rs1_ena=0.
6. jalr x0, imm=0x100 -> prdt_pc=0x100 in 0 cycles, bpu_wait=0, even when oitf_empty=0.
